// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 next-PC stage.
// Holds the PC source select encodings and the default PC width / reset PC.
package mips16_pkg;

    localparam logic [1:0] PCSEL_ALU  = 2'b00;
    localparam logic [1:0] PCSEL_DEST = 2'b01;
    localparam logic [1:0] PCSEL_JUMP = 2'b10;
    localparam logic [1:0] PCSEL_RET  = 2'b11;

    localparam int          DEF_PC_W     = 6;
    localparam int unsigned DEF_RESET_PC = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for the next-PC stage.
// Ports: clock, reset (sync, active-high), push/pop requests, push_data,
// top (current top entry), count (valid entries), ovf/unf (combinational
// overflow/underflow indications for the current request).
import mips16_pkg::*;

module pc_ras #(
    parameter int PC_W      = DEF_PC_W,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PC_W-1:0]            push_data,
    output logic [PC_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       ovf,
    output logic                       unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL);
    assign ovf   = push & full;
    assign unf   = pop & empty;
    assign top   = mem_q[ptr_q];
    assign count = cnt_q;

    // ptr_q always names the top entry; a push when full wraps onto
    // the oldest slot while the counter saturates.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (!full) cnt_d = cnt_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) mem_q[ptr_d] <= push_data;
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC stage: selects ALU/dest/jump/return target and registers the PC.
// Ports: clock, reset, stall, orig_pc, call, alu_out, dest, jump -> pc,
// ras_count, ras_err. Return stack exists only when PC_RAS_EN is defined.
import mips16_pkg::*;

module pc_next_unit #(
    parameter int          DATA_W    = 16,
    parameter int          PC_W      = DEF_PC_W,
    parameter int          RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [1:0]                 orig_pc,
    input  logic                       call,
    input  logic [DATA_W-1:0]          alu_out,
    input  logic [DATA_W-1:0]          dest,
    input  logic [DATA_W-1:0]          jump,
    output logic [PC_W-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_err
);

    localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;

`ifdef PC_RAS_EN
    logic            push, pop, ovf, unf;
    logic [PC_W-1:0] top;

    assign push = !stall && (orig_pc == PCSEL_JUMP) && call;
    assign pop  = !stall && (orig_pc == PCSEL_RET);

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + {{(PC_W-1){1'b0}}, 1'b1}),
        .top       (top),
        .count     (ras_count),
        .ovf       (ovf),
        .unf       (unf)
    );

    assign err_d = ovf | unf;
`else
    logic unused_call;
    assign unused_call = call;
    assign ras_count   = '0;
    assign err_d       = 1'b0;
`endif

    // Upper bus bits beyond PC_W are intentionally dropped.
    logic unused_hi;
    assign unused_hi = ^{alu_out, dest, jump};

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            unique case (orig_pc)
                PCSEL_ALU:  pc_d = alu_out[PC_W-1:0];
                PCSEL_DEST: pc_d = dest[PC_W-1:0];
                PCSEL_JUMP: pc_d = jump[PC_W-1:0];
                PCSEL_RET: begin
`ifdef PC_RAS_EN
                    if (!unf) pc_d = top;
`endif
                end
                default:    pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= RST_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc      = pc_q;
    assign ras_err = err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit.
// Expectations follow the PC_RAS_EN setting of the build.
module tb_pc_next_unit;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, stall, call;
    logic [1:0]  orig_pc;
    logic [15:0] alu_out, dest, jump;
    logic [5:0]  pc;
    logic [2:0]  ras_count;
    logic        ras_err;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pc_next_unit #(
        .DATA_W    (16),
        .PC_W      (6),
        .RAS_DEPTH (4),
        .RESET_PC  (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .orig_pc   (orig_pc),
        .call      (call),
        .alu_out   (alu_out),
        .dest      (dest),
        .jump      (jump),
        .pc        (pc),
        .ras_count (ras_count),
        .ras_err   (ras_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [5:0] v);
        orig_pc = 2'b01; call = 1'b0; dest = {10'h0, v};
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; orig_pc = 2'b11; call = 1'b0;
        alu_out = 16'h0; dest = 16'h0; jump = 16'h0;
        step(); step();
        checks += 3;
        if (pc !== 6'h05) begin
            failures++; $display("FAIL reset_pc got=%h exp=05", pc);
        end
        if (ras_count !== 3'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d exp=0", ras_count);
        end
        if (ras_err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", ras_err);
        end
        reset = 1'b0; stall = 1'b0; orig_pc = 2'b00; alu_out = 16'h0006;
        step();
        checks++;
        if (pc !== 6'h06) begin
            failures++; $display("FAIL release_pc got=%h exp=06", pc);
        end
    endtask

    task automatic test_select();
        orig_pc = 2'b00; alu_out = 16'hFF21; step();
        checks++;
        if (pc !== 6'h21) begin
            failures++; $display("FAIL sel_alu got=%h exp=21", pc);
        end
        orig_pc = 2'b01; dest = 16'h0013; step();
        checks++;
        if (pc !== 6'h13) begin
            failures++; $display("FAIL sel_dest got=%h exp=13", pc);
        end
        orig_pc = 2'b10; jump = 16'h003E; step();
        checks++;
        if (pc !== 6'h3E) begin
            failures++; $display("FAIL sel_jump got=%h exp=3E", pc);
        end
    endtask

    task automatic test_call_return();
        set_pc(6'h3F);
        orig_pc = 2'b10; call = 1'b1; jump = 16'h0010; step();
        checks += 2;
        if (pc !== 6'h10) begin
            failures++; $display("FAIL call_pc got=%h exp=10", pc);
        end
        if (ras_count !== (RAS ? 3'd1 : 3'd0)) begin
            failures++; $display("FAIL call_cnt got=%0d exp=%0d", ras_count, RAS ? 1 : 0);
        end
        orig_pc = 2'b11; call = 1'b0; step();
        checks += 3;
        if (pc !== (RAS ? 6'h00 : 6'h10)) begin
            failures++; $display("FAIL ret_pc got=%h exp=%h", pc, RAS ? 6'h00 : 6'h10);
        end
        if (ras_count !== 3'd0) begin
            failures++; $display("FAIL ret_cnt got=%0d exp=0", ras_count);
        end
        if (ras_err !== 1'b0) begin
            failures++; $display("FAIL ret_err got=%b exp=0", ras_err);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] exp_pc;
        set_pc(6'h01);
        for (int i = 1; i <= 5; i++) begin
            orig_pc = 2'b10; call = 1'b1;
            jump = (i == 5) ? 16'h0020 : 16'(i + 1);
            step();
            if (i >= 4) begin
                checks++;
                if (ras_err !== ((i == 5) && RAS)) begin
                    failures++; $display("FAIL ovf_err%0d got=%b", i, ras_err);
                end
            end
        end
        checks++;
        if (ras_count !== (RAS ? 3'd4 : 3'd0)) begin
            failures++; $display("FAIL ovf_cnt got=%0d exp=%0d", ras_count, RAS ? 4 : 0);
        end
        call = 1'b0; orig_pc = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_pc = RAS ? ((i < 4) ? 6'(6 - i) : 6'h03) : 6'h20;
            checks += 2;
            if (pc !== exp_pc) begin
                failures++; $display("FAIL pop%0d_pc got=%h exp=%h", i, pc, exp_pc);
            end
            if (ras_err !== ((i == 4) && RAS)) begin
                failures++; $display("FAIL pop%0d_err got=%b", i, ras_err);
            end
        end
        set_pc(6'h07);
        checks++;
        if (ras_err !== 1'b0) begin
            failures++; $display("FAIL err_pulse got=%b exp=0", ras_err);
        end
    endtask

    task automatic test_stall();
        orig_pc = 2'b10; call = 1'b1; jump = 16'h0030; step();
        jump = 16'h0038; step();
        call = 1'b0; orig_pc = 2'b11; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 3;
            if (pc !== 6'h38) begin
                failures++; $display("FAIL stall%0d_pc got=%h exp=38", i, pc);
            end
            if (ras_count !== (RAS ? 3'd2 : 3'd0)) begin
                failures++; $display("FAIL stall%0d_cnt got=%0d", i, ras_count);
            end
            if (ras_err !== 1'b0) begin
                failures++; $display("FAIL stall%0d_err got=%b", i, ras_err);
            end
        end
        stall = 1'b0; step();
        checks += 2;
        if (pc !== (RAS ? 6'h31 : 6'h38)) begin
            failures++; $display("FAIL unstall_pc got=%h exp=%h", pc, RAS ? 6'h31 : 6'h38);
        end
        if (ras_count !== (RAS ? 3'd1 : 3'd0)) begin
            failures++; $display("FAIL unstall_cnt got=%0d", ras_count);
        end
    endtask

    task automatic test_reset_mid();
        orig_pc = 2'b10; call = 1'b1; jump = 16'h002A; step();
        jump = 16'h002B; step();
        checks++;
        if (ras_count !== (RAS ? 3'd3 : 3'd0)) begin
            failures++; $display("FAIL mid_cnt got=%0d", ras_count);
        end
        reset = 1'b1; jump = 16'h0011; step();
        checks += 2;
        if (pc !== 6'h05) begin
            failures++; $display("FAIL mid_rst_pc got=%h exp=05", pc);
        end
        if (ras_count !== 3'd0) begin
            failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", ras_count);
        end
        reset = 1'b0; call = 1'b0; orig_pc = 2'b11; step();
        checks += 3;
        if (pc !== 6'h05) begin
            failures++; $display("FAIL mid_unf_pc got=%h exp=05", pc);
        end
        if (ras_err !== RAS) begin
            failures++; $display("FAIL mid_unf_err got=%b exp=%b", ras_err, RAS);
        end
        if (ras_count !== 3'd0) begin
            failures++; $display("FAIL mid_unf_cnt got=%0d exp=0", ras_count);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_call_return();
        test_overflow();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised next-PC stage for the multicycle/pipelined MIPS16 core, superseding the old combinational PC-source mux. Selects the next fetch address from the ALU result, the branch destination, the jump target or a return-address stack. It registers the selected address as the architectural PC and supports stall.

## Interface
- `DATA_W`, 16: width of the `alu_out`, `dest` and `jump` datapath buses.
- `PC_W`, 6: width of the PC and instruction-memory address; it must satisfy PC_W ≤ DATA_W.
- `RAS_DEPTH`, 4: number of return-stack entries; it must be a power of two, ≥ 2.
- `RESET_PC`, 0: PC value loaded on reset, PC_W bits.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: when 1, hold all state and ignore `orig_pc` and `call`.
- `orig_pc` input 2: source select; 00 = ALU, 01 = dest, 10 = jump, 11 = return (pop).
- `call` input 1: when 1 with `orig_pc`=10, push pc+1 onto the return stack.
- `alu_out` input DATA_W: ALU result (normally PC+1).
- `dest` input DATA_W: branch destination.
- `jump` input DATA_W: jump target.
- `pc` output PC_W: registered current PC.
- `ras_count` output clog2(RAS_DEPTH)+1: number of valid stack entries.
- `ras_err` output 1: one-cycle pulse on a stack overflow or underflow.

## Operation
- The unit selects the next PC every unstalled cycle. It takes the low PC_W bits of the selected bus; the upper bits are discarded with no check.
- For 00, 01 and 10, `pc` ← `alu_out`, `dest` or `jump` [PC_W-1:0] respectively.
- For 11 (return) with `ras_count`>0, `pc` ← top of stack and `ras_count` decrements.
- For 11 (return) with `ras_count`=0 (underflow), `pc` holds its value and `ras_err` pulses.
- For 10 with `call`=1, the unit pushes (`pc`+1) mod 2^PC_W and sets `pc` ← `jump`.
  - If the stack is full, the push overwrites the oldest entry (circular) and `ras_count` stays at RAS_DEPTH.
  - The overflow also pulses `ras_err`.
- `call` with any `orig_pc` other than 10 is ignored; it causes no push and no error.
- The stack is a circular buffer: a top pointer of clog2(RAS_DEPTH) bits with wrap-around, plus a saturating counter.
- When `stall`=1, `pc`, the stack contents, the pointer and `ras_count` all hold, and `ras_err`=0.
- Reset is synchronous and overrides `stall`:
  - `pc`=RESET_PC, `ras_count`=0, top pointer = 0, `ras_err`=0.
  - Stack contents are don't-care.
  - A reset in the same cycle as a push or pop discards that push or pop.

## Timing
- One-cycle latency: inputs sampled at edge N appear on `pc` after edge N. The next-PC logic is combinational, with no extra pipeline stage.
- `ras_err` is registered. It is high for exactly the one cycle following the erroring edge.
- The popped value is the entry written by the most recent unpopped push, including a push made on the immediately preceding cycle. A back-to-back call then return returns pc_call+1.
- Outputs are valid from the first edge after `reset` deasserts. While `reset` is held, `pc` = RESET_PC.

## Configuration
- `PC_RAS_EN` defined: return stack, `call` push, select 11 and `ras_err` are all implemented as described above.
- `PC_RAS_EN` undefined:
  - There is no stack storage.
  - Select 11 holds `pc`.
  - `call` is ignored.
  - `ras_count` and `ras_err` are tied to 0.
  - Port list is unchanged.

## Structure
- Shared package `mips16_pkg` holds:
  - the select localparams: `PCSEL_ALU`=2'b00, `PCSEL_DEST`=2'b01, `PCSEL_JUMP`=2'b10, `PCSEL_RET`=2'b11;
  - the default `PC_W` and `RESET_PC`.
- One sub-module, `pc_ras`: the circular return-address stack, with `push`/`pop`/`push_data`/`top`/`count`/`ovf`/`unf` and parameters `PC_W` and `RAS_DEPTH`. It is instantiated only under `PC_RAS_EN`.

## Test plan
- Reset: assert `reset` for 2 cycles with RESET_PC=6'h05 and `stall`=1 → `pc`=05, `ras_count`=0, `ras_err`=0. After release with sel 00 and alu_out=16'h0006 → `pc`=06.
- Select coverage: sel 00 with alu_out=16'hFF21 → `pc`=21 (truncation); sel 01 with dest=16'h0013 → `pc`=13; sel 10 with jump=16'h003E → `pc`=3E.
- Call/return: at pc=3F, apply sel 10, call=1, jump=10 → `pc`=10, `ras_count`=1. The next cycle, sel 11 → `pc`=00 (wrap of 3F+1), `ras_count`=0.
- Overflow: RAS_DEPTH=4, make 5 calls from pcs 01, 02, 03, 04, 05 → `ras_err` pulses after the 5th, count=4. Then 4 returns yield 06, 05, 04, 03; a 5th return → `pc` holds, `ras_err` pulses.
- Stall: with stall=1, sel 11 and count=2 for 3 cycles → `pc`, `ras_count` unchanged, `ras_err`=0. Releasing stall pops normally.
- Reset mid-operation: count=3 with reset and a call asserted together → `pc`=RESET_PC, `ras_count`=0. A following return underflows with `ras_err`=1.
